ram_input_loader: RTL and testbench

// - Upstream fill stage for the 1-bit input RAM: takes bytes from the UART receiver,

---
 rtl/ram_input_loader_pkg.sv | 14 +
 rtl/ram_input_loader.sv | 90 +++++++++
 tb/tb_ram_input_loader.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_input_loader_pkg.sv
// Shared types for the input-RAM fill path.
// Used by the loader and the downstream sequencer.
package ram_input_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        UNPACK    = 2'd2,
        DONE      = 2'd3
    } loader_state_t;

    localparam int IMG_INPUTS = 784;

endpackage

// File: rtl/ram_input_loader.sv
// Unpacks UART bytes LSB-first into consecutive bits of the 1-bit input RAM.
// Fills one image of NUM_INPUTS bits, then holds done until restarted.
module ram_input_loader
    import ram_input_loader_pkg::*;
#(
    parameter int NUM_INPUTS = IMG_INPUTS,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rx_rdy,
    input  logic [BYTE_WIDTH-1:0] rx_data,
    output logic                  clr_rx_rdy,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  data,
    output logic                  busy,
    output logic                  done
);

    localparam int BIT_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INPUTS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_WIDTH - 1);

    loader_state_t state;
    loader_state_t state_nxt;
    logic [BYTE_WIDTH-1:0] shift;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic capture;
    logic unpack;
    logic last_addr;

    // start pre-empts a pending byte; it is taken on the following cycle
    assign capture   = (state == WAIT_BYTE) && rx_rdy && !start;
    assign unpack    = (state == UNPACK);
    assign last_addr = (addr_cnt == LAST_ADDR);

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = WAIT_BYTE;
        end else begin
            unique case (state)
                IDLE: state_nxt = IDLE;
                WAIT_BYTE: begin
                    if (rx_rdy) state_nxt = UNPACK;
                end
                UNPACK: begin
                    if (last_addr) state_nxt = DONE;
                    else if (bit_cnt == LAST_BIT) state_nxt = WAIT_BYTE;
                end
                DONE: state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            addr_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                addr_cnt <= '0;
                bit_cnt  <= '0;
            end else if (capture) begin
                shift <= rx_data;
            end else if (unpack) begin
                shift   <= shift >> 1;
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                // hold on the final address so addr stays in range in DONE
                if (!last_addr) addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    assign clr_rx_rdy = capture;
    assign we         = unpack;
    assign data       = unpack & shift[0];
    assign addr       = addr_cnt;
    assign busy       = (state == WAIT_BYTE) || unpack;
    assign done       = (state == DONE);

endmodule

// File: tb/tb_ram_input_loader.sv
// Self-checking bench for ram_input_loader.
// Main instance fills a 784-bit image; a second instance covers a ragged 10-bit image.
`timescale 1ns/1ps
module tb_ram_input_loader;

    typedef logic [7:0] byte_q_t[$];

    logic clk;
    logic rst_n;
    logic start;
    logic rx_rdy;
    logic [7:0] rx_data;
    logic clr_rx_rdy;
    logic we;
    logic [9:0] addr;
    logic data;
    logic busy;
    logic done;

    logic s_start;
    logic s_rx_rdy;
    logic [7:0] s_rx_data;
    logic s_clr;
    logic s_we;
    logic [9:0] s_addr;
    logic s_data;
    logic s_busy;
    logic s_done;

    int n_run = 0;
    int n_fail = 0;

    int clr_cyc[$];
    int wr_cyc[$];
    int wr_addr[$];
    bit wr_dat[$];
    int done_cyc;
    bit ram[0:1023];

    ram_input_loader #(
        .NUM_INPUTS(784),
        .ADDR_WIDTH(10),
        .BYTE_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .rx_rdy(rx_rdy),
        .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy),
        .we(we),
        .addr(addr),
        .data(data),
        .busy(busy),
        .done(done)
    );

    ram_input_loader #(
        .NUM_INPUTS(10),
        .ADDR_WIDTH(10),
        .BYTE_WIDTH(8)
    ) dut_small (
        .clk(clk),
        .rst_n(rst_n),
        .start(s_start),
        .rx_rdy(s_rx_rdy),
        .rx_data(s_rx_data),
        .clr_rx_rdy(s_clr),
        .we(s_we),
        .addr(s_addr),
        .data(s_data),
        .busy(s_busy),
        .done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    // Reference: bit i of the image is bit (i%8) of byte i/8; with a byte always
    // ready, byte k is captured at cycle 9k+1 and its bits written at 9k+2..9k+9.
    function automatic int bad_writes(input byte_q_t b, input int n);
        int bad;
        logic [7:0] v;
        bad = 0;
        for (int i = 0; i < n && i < wr_cyc.size(); i++) begin
            v = b[i / 8];
            if (wr_addr[i] != i) bad++;
            else if (wr_dat[i] !== v[i % 8]) bad++;
            else if (wr_cyc[i] != 9 * (i / 8) + 2 + i % 8) bad++;
        end
        return bad;
    endfunction

    function automatic int bad_ram(input byte_q_t b, input int n);
        int bad;
        logic [7:0] v;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            v = b[i / 8];
            if (ram[i] !== v[i % 8]) bad++;
        end
        return bad;
    endfunction

    // Pulses start, then acts as a UART that presents the next byte as soon as
    // the previous one is consumed, recording every RAM write and handshake.
    task automatic run_load(input byte_q_t bytes, input int max_cyc);
        int idx;
        idx = 0;
        clr_cyc.delete();
        wr_cyc.delete();
        wr_addr.delete();
        wr_dat.delete();
        done_cyc = -1;
        @(posedge clk);
        #1;
        rx_data = bytes[0];
        rx_rdy = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (we) begin
                wr_cyc.push_back(c);
                wr_addr.push_back(int'(addr));
                wr_dat.push_back(data);
                ram[addr] = data;
            end
            if (clr_rx_rdy) begin
                clr_cyc.push_back(c);
                idx++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
            if (idx < bytes.size()) rx_data = bytes[idx];
            else rx_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rx_rdy = 1'b0;
        rx_data = 8'h00;
        s_start = 1'b0;
        s_rx_rdy = 1'b0;
        s_rx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_run++;
        if ({clr_rx_rdy, we, data, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {clr_rx_rdy, we, data, busy, done});
        end
        n_run++;
        if (addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_addr got=%0d want=0", addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_rdy = 1'b1;
        rx_data = 8'h5A;
        repeat (2) @(negedge clk);
        n_run++;
        if ({clr_rx_rdy, we, busy, done} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_rx got=%b want=0000",
                     {clr_rx_rdy, we, busy, done});
        end
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
    endtask

    task automatic test_byte_timing();
        byte_q_t b;
        int bw;
        b = {8'h01};
        run_load(b, 12);
        n_run++;
        if (clr_cyc.size() != 1 || clr_cyc[0] != 1) begin
            n_fail++;
            $display("FAIL timing_clr count=%0d first=%0d want count=1 first=1",
                     clr_cyc.size(), (clr_cyc.size() > 0) ? clr_cyc[0] : -1);
        end
        n_run++;
        if (wr_cyc.size() != 8) begin
            n_fail++;
            $display("FAIL timing_writes got=%0d want=8", wr_cyc.size());
        end
        bw = bad_writes(b, 8);
        n_run++;
        if (bw != 0) begin
            n_fail++;
            $display("FAIL timing_bits bad=%0d want=0", bw);
        end
        n_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL timing_wait_state busy=%b done=%b want busy=1 done=0",
                     busy, done);
        end
    endtask

    task automatic test_backpressure();
        byte_q_t b;
        int bw;
        b = {8'hFF, 8'hFF};
        run_load(b, 25);
        n_run++;
        if (clr_cyc.size() != 2 || clr_cyc[1] != 10) begin
            n_fail++;
            $display("FAIL bp_capture count=%0d second=%0d want count=2 second=10",
                     clr_cyc.size(), (clr_cyc.size() > 1) ? clr_cyc[1] : -1);
        end
        n_run++;
        if (wr_cyc.size() != 16) begin
            n_fail++;
            $display("FAIL bp_writes got=%0d want=16", wr_cyc.size());
        end
        bw = bad_writes(b, 16);
        n_run++;
        if (bw != 0) begin
            n_fail++;
            $display("FAIL bp_bits bad=%0d want=0", bw);
        end
    endtask

    task automatic test_full_image();
        byte_q_t b;
        logic [7:0] pat;
        int bw;
        int bad;
        int cbad;
        pat = 8'b1010_0101;
        b = {};
        for (int i = 0; i < 98; i++) b.push_back(8'hA5);
        run_load(b, 1000);
        n_run++;
        if (wr_cyc.size() != 784) begin
            n_fail++;
            $display("FAIL a5_write_count got=%0d want=784", wr_cyc.size());
        end
        n_run++;
        if (clr_cyc.size() != 98) begin
            n_fail++;
            $display("FAIL a5_clr_count got=%0d want=98", clr_cyc.size());
        end
        cbad = 0;
        for (int k = 0; k < clr_cyc.size(); k++)
            if (clr_cyc[k] != 9 * k + 1) cbad++;
        n_run++;
        if (cbad != 0) begin
            n_fail++;
            $display("FAIL a5_clr_timing bad=%0d want=0", cbad);
        end
        bw = bad_writes(b, 784);
        n_run++;
        if (bw != 0) begin
            n_fail++;
            $display("FAIL a5_writes bad=%0d want=0", bw);
        end
        bad = 0;
        for (int i = 0; i < 784; i++)
            if (ram[i] !== pat[7 - (i % 8)]) bad++;
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL a5_pattern bad=%0d want=0", bad);
        end
        n_run++;
        if (done_cyc != 883) begin
            n_fail++;
            $display("FAIL a5_done_cycle got=%0d want=883", done_cyc);
        end
        n_run++;
        if (addr !== 10'd783 || we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_done_state addr=%0d we=%b busy=%b want 783 0 0",
                     addr, we, busy);
        end
    endtask

    task automatic test_random_image();
        byte_q_t b;
        int bw;
        int br;
        b = rand_bytes(98);
        run_load(b, 1000);
        bw = bad_writes(b, 784);
        br = bad_ram(b, 784);
        n_run++;
        if (bw != 0 || wr_cyc.size() != 784) begin
            n_fail++;
            $display("FAIL rand_writes bad=%0d count=%0d want bad=0 count=784",
                     bw, wr_cyc.size());
        end
        n_run++;
        if (br != 0) begin
            n_fail++;
            $display("FAIL rand_ram bad=%0d want=0", br);
        end
        n_run++;
        if (done_cyc != 883 || clr_cyc.size() != 98) begin
            n_fail++;
            $display("FAIL rand_done cycle=%0d clrs=%0d want 883 98",
                     done_cyc, clr_cyc.size());
        end
    endtask

    task automatic test_restart();
        byte_q_t b1;
        byte_q_t b2;
        int bw;
        int br;
        b1 = rand_bytes(40);
        run_load(b1, 338);
        n_run++;
        if (wr_cyc.size() != 300 || done_cyc != -1) begin
            n_fail++;
            $display("FAIL restart_partial writes=%0d done_cyc=%0d want 300 -1",
                     wr_cyc.size(), done_cyc);
        end
        b2 = rand_bytes(98);
        run_load(b2, 1000);
        n_run++;
        if (wr_cyc.size() < 8 || wr_addr[0] != 0 || wr_addr[7] != 7) begin
            n_fail++;
            $display("FAIL restart_addr0 first=%0d want=0",
                     (wr_addr.size() > 0) ? wr_addr[0] : -1);
        end
        bw = bad_writes(b2, 784);
        br = bad_ram(b2, 784);
        n_run++;
        if (bw != 0 || br != 0 || wr_cyc.size() != 784) begin
            n_fail++;
            $display("FAIL restart_image bad_wr=%0d bad_ram=%0d count=%0d want 0 0 784",
                     bw, br, wr_cyc.size());
        end
        n_run++;
        if (done_cyc != 883) begin
            n_fail++;
            $display("FAIL restart_done got=%0d want=883", done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t b;
        int bw;
        b = rand_bytes(98);
        run_load(b, 20);
        n_run++;
        if (we !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_in_unpack we=%b busy=%b want 1 1", we, busy);
        end
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({we, busy, done, clr_rx_rdy} !== 4'b0 || addr !== 10'd0) begin
            n_fail++;
            $display("FAIL rstmid_async outs=%b addr=%0d want 0000 0",
                     {we, busy, done, clr_rx_rdy}, addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_run++;
        if ({clr_rx_rdy, busy, we} !== 3'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle outs=%b want 000", {clr_rx_rdy, busy, we});
        end
        b = rand_bytes(98);
        run_load(b, 1000);
        bw = bad_writes(b, 784);
        n_run++;
        if (bw != 0 || wr_cyc.size() != 784 || done_cyc != 883) begin
            n_fail++;
            $display("FAIL rstmid_reload bad=%0d count=%0d done=%0d want 0 784 883",
                     bw, wr_cyc.size(), done_cyc);
        end
    endtask

    task automatic test_ragged();
        int nw;
        int nclr;
        int bad;
        int dcnt;
        int late_wr;
        nw = 0;
        nclr = 0;
        bad = 0;
        dcnt = 0;
        late_wr = 0;
        @(posedge clk);
        #1;
        s_rx_data = 8'hFF;
        s_rx_rdy = 1'b1;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (s_we) begin
                if (int'(s_addr) != nw || s_data !== 1'b1) bad++;
                if (s_done || s_addr >= 10'd10) late_wr++;
                nw++;
            end
            if (s_clr) nclr++;
            if (s_done) dcnt++;
            @(posedge clk);
            #1;
            s_rx_data = (nclr == 1) ? 8'h03 : 8'hAA;
        end
        n_run++;
        if (nw != 10 || bad != 0) begin
            n_fail++;
            $display("FAIL ragged_writes count=%0d bad=%0d want 10 0", nw, bad);
        end
        n_run++;
        if (late_wr != 0 || s_addr !== 10'd9) begin
            n_fail++;
            $display("FAIL ragged_bound late=%0d addr=%0d want 0 9", late_wr, s_addr);
        end
        n_run++;
        if (nclr != 2) begin
            n_fail++;
            $display("FAIL ragged_clr got=%0d want=2", nclr);
        end
        n_run++;
        if (dcnt != 28 || s_done !== 1'b1) begin
            n_fail++;
            $display("FAIL ragged_done cycles=%0d done=%b want 28 1", dcnt, s_done);
        end
        s_rx_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_byte_timing();
        test_backpressure();
        test_full_image();
        test_random_image();
        test_restart();
        test_reset_mid();
        test_ragged();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
